// File: rtl/axi4_mem_arbiter_pkg.sv
// rtl/axi4_mem_arbiter_pkg.sv - shared state encodings and AXI constants for the memory arbiter
package axi4_mem_arbiter_pkg;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wr_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
endpackage

// File: rtl/axi4_mem_arbiter_rr_arb2.sv
// rtl/axi4_mem_arbiter_rr_arb2.sv - two-requester round-robin arbiter
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       winner_o
);
  logic ptr_q, ptr_d;

  // The pointer only matters on a tie; a lone requester always wins.
  assign winner_o = (req_i == 2'b11) ? ptr_q : req_i[1];
  assign ptr_d    = update_i ? ~winner_o : ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/axi4_mem_arbiter.sv
// rtl/axi4_mem_arbiter.sv - two-master to one-slave AXI4 arbiter, independent read/write paths
module axi4_mem_arbiter
  import axi4_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 31,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                s0_axi4_awvalid, s1_axi4_awvalid,
  output logic                s0_axi4_awready, s1_axi4_awready,
  input  logic [ID_W-1:0]     s0_axi4_awid, s1_axi4_awid,
  input  logic [ADDR_W-1:0]   s0_axi4_awaddr, s1_axi4_awaddr,
  input  logic [7:0]          s0_axi4_awlen, s1_axi4_awlen,
  input  logic [2:0]          s0_axi4_awsize, s1_axi4_awsize,
  input  logic [1:0]          s0_axi4_awburst, s1_axi4_awburst,
  input  logic                s0_axi4_wvalid, s1_axi4_wvalid,
  output logic                s0_axi4_wready, s1_axi4_wready,
  input  logic [DATA_W-1:0]   s0_axi4_wdata, s1_axi4_wdata,
  input  logic [DATA_W/8-1:0] s0_axi4_wstrb, s1_axi4_wstrb,
  input  logic                s0_axi4_wlast, s1_axi4_wlast,
  output logic                s0_axi4_bvalid, s1_axi4_bvalid,
  input  logic                s0_axi4_bready, s1_axi4_bready,
  output logic [ID_W-1:0]     s0_axi4_bid, s1_axi4_bid,
  output logic [1:0]          s0_axi4_bresp, s1_axi4_bresp,
  input  logic                s0_axi4_arvalid, s1_axi4_arvalid,
  output logic                s0_axi4_arready, s1_axi4_arready,
  input  logic [ID_W-1:0]     s0_axi4_arid, s1_axi4_arid,
  input  logic [ADDR_W-1:0]   s0_axi4_araddr, s1_axi4_araddr,
  input  logic [7:0]          s0_axi4_arlen, s1_axi4_arlen,
  input  logic [2:0]          s0_axi4_arsize, s1_axi4_arsize,
  input  logic [1:0]          s0_axi4_arburst, s1_axi4_arburst,
  output logic                s0_axi4_rvalid, s1_axi4_rvalid,
  input  logic                s0_axi4_rready, s1_axi4_rready,
  output logic [ID_W-1:0]     s0_axi4_rid, s1_axi4_rid,
  output logic [DATA_W-1:0]   s0_axi4_rdata, s1_axi4_rdata,
  output logic [1:0]          s0_axi4_rresp, s1_axi4_rresp,
  output logic                s0_axi4_rlast, s1_axi4_rlast,
  output logic                m_axi4_awvalid,
  input  logic                m_axi4_awready,
  output logic [ID_W-1:0]     m_axi4_awid,
  output logic [ADDR_W-1:0]   m_axi4_awaddr,
  output logic [7:0]          m_axi4_awlen,
  output logic [2:0]          m_axi4_awsize,
  output logic [1:0]          m_axi4_awburst,
  output logic                m_axi4_wvalid,
  input  logic                m_axi4_wready,
  output logic [DATA_W-1:0]   m_axi4_wdata,
  output logic [DATA_W/8-1:0] m_axi4_wstrb,
  output logic                m_axi4_wlast,
  input  logic                m_axi4_bvalid,
  output logic                m_axi4_bready,
  input  logic [ID_W-1:0]     m_axi4_bid,
  input  logic [1:0]          m_axi4_bresp,
  output logic                m_axi4_arvalid,
  input  logic                m_axi4_arready,
  output logic [ID_W-1:0]     m_axi4_arid,
  output logic [ADDR_W-1:0]   m_axi4_araddr,
  output logic [7:0]          m_axi4_arlen,
  output logic [2:0]          m_axi4_arsize,
  output logic [1:0]          m_axi4_arburst,
  input  logic                m_axi4_rvalid,
  output logic                m_axi4_rready,
  input  logic [ID_W-1:0]     m_axi4_rid,
  input  logic [DATA_W-1:0]   m_axi4_rdata,
  input  logic [1:0]          m_axi4_rresp,
  input  logic                m_axi4_rlast,
  output logic                wr_owner,
  output logic                rd_owner,
  output logic                wr_busy,
  output logic                rd_busy
);
  wr_state_e wr_q;
  rd_state_e rd_q;
  logic      wr_own_q, rd_own_q;
  logic      wr_win, rd_win, wr_grant, rd_grant;
  logic      wo, ro, w_addr, w_data, w_resp, r_addr, r_data;

  assign wr_grant = (wr_q == W_IDLE) && (s0_axi4_awvalid || s1_axi4_awvalid);
  assign rd_grant = (rd_q == R_IDLE) && (s0_axi4_arvalid || s1_axi4_arvalid);

  rr_arb2 u_wr_arb (.clk_i(clock), .rst_i(reset), .req_i({s1_axi4_awvalid, s0_axi4_awvalid}),
                    .update_i(wr_grant), .winner_o(wr_win));
  rr_arb2 u_rd_arb (.clk_i(clock), .rst_i(reset), .req_i({s1_axi4_arvalid, s0_axi4_arvalid}),
                    .update_i(rd_grant), .winner_o(rd_win));

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q     <= W_IDLE;
      wr_own_q <= 1'b0;
    end else begin
      case (wr_q)
        W_IDLE: if (wr_grant) begin wr_own_q <= wr_win; wr_q <= W_ADDR; end
        W_ADDR: if (m_axi4_awvalid && m_axi4_awready) wr_q <= W_DATA;
        W_DATA: if (m_axi4_wvalid && m_axi4_wready && m_axi4_wlast) wr_q <= W_RESP;
        W_RESP: if (m_axi4_bvalid && m_axi4_bready) wr_q <= W_IDLE;
        default: wr_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q     <= R_IDLE;
      rd_own_q <= 1'b0;
    end else begin
      case (rd_q)
        R_IDLE: if (rd_grant) begin rd_own_q <= rd_win; rd_q <= R_ADDR; end
        R_ADDR: if (m_axi4_arvalid && m_axi4_arready) rd_q <= R_DATA;
        R_DATA: if (m_axi4_rvalid && m_axi4_rready && m_axi4_rlast) rd_q <= R_IDLE;
        default: rd_q <= R_IDLE;
      endcase
    end
  end

  assign wo = wr_own_q;
  assign ro = rd_own_q;
  assign w_addr = (wr_q == W_ADDR);
  assign w_data = (wr_q == W_DATA);
  assign w_resp = (wr_q == W_RESP);
  assign r_addr = (rd_q == R_ADDR);
  assign r_data = (rd_q == R_DATA);

  assign wr_owner = wr_own_q;
  assign rd_owner = rd_own_q;
  assign wr_busy  = (wr_q != W_IDLE);
  assign rd_busy  = (rd_q != R_IDLE);

  // Slave-facing payload is the owner's in the matching state and zero otherwise.
  assign m_axi4_awvalid = w_addr & (wo ? s1_axi4_awvalid : s0_axi4_awvalid);
  assign m_axi4_awid    = w_addr ? (wo ? s1_axi4_awid    : s0_axi4_awid)    : '0;
  assign m_axi4_awaddr  = w_addr ? (wo ? s1_axi4_awaddr  : s0_axi4_awaddr)  : '0;
  assign m_axi4_awlen   = w_addr ? (wo ? s1_axi4_awlen   : s0_axi4_awlen)   : '0;
  assign m_axi4_awsize  = w_addr ? (wo ? s1_axi4_awsize  : s0_axi4_awsize)  : '0;
  assign m_axi4_awburst = w_addr ? (wo ? s1_axi4_awburst : s0_axi4_awburst) : '0;
  assign m_axi4_wvalid  = w_data & (wo ? s1_axi4_wvalid : s0_axi4_wvalid);
  assign m_axi4_wdata   = w_data ? (wo ? s1_axi4_wdata : s0_axi4_wdata) : '0;
  assign m_axi4_wstrb   = w_data ? (wo ? s1_axi4_wstrb : s0_axi4_wstrb) : '0;
  assign m_axi4_wlast   = w_data & (wo ? s1_axi4_wlast : s0_axi4_wlast);
  assign m_axi4_bready  = w_resp & (wo ? s1_axi4_bready : s0_axi4_bready);
  assign m_axi4_arvalid = r_addr & (ro ? s1_axi4_arvalid : s0_axi4_arvalid);
  assign m_axi4_arid    = r_addr ? (ro ? s1_axi4_arid    : s0_axi4_arid)    : '0;
  assign m_axi4_araddr  = r_addr ? (ro ? s1_axi4_araddr  : s0_axi4_araddr)  : '0;
  assign m_axi4_arlen   = r_addr ? (ro ? s1_axi4_arlen   : s0_axi4_arlen)   : '0;
  assign m_axi4_arsize  = r_addr ? (ro ? s1_axi4_arsize  : s0_axi4_arsize)  : '0;
  assign m_axi4_arburst = r_addr ? (ro ? s1_axi4_arburst : s0_axi4_arburst) : '0;
  assign m_axi4_rready  = r_data & (ro ? s1_axi4_rready : s0_axi4_rready);

  assign s0_axi4_awready = w_addr & ~wo & m_axi4_awready;
  assign s1_axi4_awready = w_addr &  wo & m_axi4_awready;
  assign s0_axi4_wready  = w_data & ~wo & m_axi4_wready;
  assign s1_axi4_wready  = w_data &  wo & m_axi4_wready;
  assign s0_axi4_bvalid  = w_resp & ~wo & m_axi4_bvalid;
  assign s1_axi4_bvalid  = w_resp &  wo & m_axi4_bvalid;
  assign s0_axi4_bid     = (w_resp & ~wo) ? m_axi4_bid   : '0;
  assign s1_axi4_bid     = (w_resp &  wo) ? m_axi4_bid   : '0;
  assign s0_axi4_bresp   = (w_resp & ~wo) ? m_axi4_bresp : '0;
  assign s1_axi4_bresp   = (w_resp &  wo) ? m_axi4_bresp : '0;

  assign s0_axi4_arready = r_addr & ~ro & m_axi4_arready;
  assign s1_axi4_arready = r_addr &  ro & m_axi4_arready;
  assign s0_axi4_rvalid  = r_data & ~ro & m_axi4_rvalid;
  assign s1_axi4_rvalid  = r_data &  ro & m_axi4_rvalid;
  assign s0_axi4_rid     = (r_data & ~ro) ? m_axi4_rid   : '0;
  assign s1_axi4_rid     = (r_data &  ro) ? m_axi4_rid   : '0;
  assign s0_axi4_rdata   = (r_data & ~ro) ? m_axi4_rdata : '0;
  assign s1_axi4_rdata   = (r_data &  ro) ? m_axi4_rdata : '0;
  assign s0_axi4_rresp   = (r_data & ~ro) ? m_axi4_rresp : '0;
  assign s1_axi4_rresp   = (r_data &  ro) ? m_axi4_rresp : '0;
  assign s0_axi4_rlast   = r_data & ~ro & m_axi4_rlast;
  assign s1_axi4_rlast   = r_data &  ro & m_axi4_rlast;
endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// tb/tb_axi4_mem_arbiter.sv - directed self-checking bench for axi4_mem_arbiter
module tb_axi4_mem_arbiter;
  import axi4_mem_arbiter_pkg::*;
  localparam int AW = 31, DW = 64, IW = 4;

  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;

  logic          s0_awvalid, s1_awvalid, s0_awready, s1_awready;
  logic [IW-1:0] s0_awid, s1_awid;
  logic [AW-1:0] s0_awaddr, s1_awaddr;
  logic [7:0]    s0_awlen, s1_awlen;
  logic [2:0]    s0_awsize, s1_awsize;
  logic [1:0]    s0_awburst, s1_awburst;
  logic          s0_wvalid, s1_wvalid, s0_wready, s1_wready, s0_wlast, s1_wlast;
  logic [DW-1:0] s0_wdata, s1_wdata;
  logic [DW/8-1:0] s0_wstrb, s1_wstrb;
  logic          s0_bvalid, s1_bvalid, s0_bready, s1_bready;
  logic [IW-1:0] s0_bid, s1_bid;
  logic [1:0]    s0_bresp, s1_bresp;
  logic          s0_arvalid, s1_arvalid, s0_arready, s1_arready;
  logic [IW-1:0] s0_arid, s1_arid;
  logic [AW-1:0] s0_araddr, s1_araddr;
  logic [7:0]    s0_arlen, s1_arlen;
  logic [2:0]    s0_arsize, s1_arsize;
  logic [1:0]    s0_arburst, s1_arburst;
  logic          s0_rvalid, s1_rvalid, s0_rready, s1_rready, s0_rlast, s1_rlast;
  logic [IW-1:0] s0_rid, s1_rid;
  logic [DW-1:0] s0_rdata, s1_rdata;
  logic [1:0]    s0_rresp, s1_rresp;

  logic          m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [IW-1:0] m_awid, m_bid, m_arid, m_rid;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [7:0]    m_awlen, m_arlen;
  logic [2:0]    m_awsize, m_arsize;
  logic [1:0]    m_awburst, m_arburst, m_bresp, m_rresp;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [DW/8-1:0] m_wstrb;
  logic          m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic          wr_owner, rd_owner, wr_busy, rd_busy;

  axi4_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clock(clock), .reset(reset),
    .s0_axi4_awvalid(s0_awvalid), .s1_axi4_awvalid(s1_awvalid), .s0_axi4_awready(s0_awready), .s1_axi4_awready(s1_awready),
    .s0_axi4_awid(s0_awid), .s1_axi4_awid(s1_awid), .s0_axi4_awaddr(s0_awaddr), .s1_axi4_awaddr(s1_awaddr),
    .s0_axi4_awlen(s0_awlen), .s1_axi4_awlen(s1_awlen), .s0_axi4_awsize(s0_awsize), .s1_axi4_awsize(s1_awsize),
    .s0_axi4_awburst(s0_awburst), .s1_axi4_awburst(s1_awburst),
    .s0_axi4_wvalid(s0_wvalid), .s1_axi4_wvalid(s1_wvalid), .s0_axi4_wready(s0_wready), .s1_axi4_wready(s1_wready),
    .s0_axi4_wdata(s0_wdata), .s1_axi4_wdata(s1_wdata), .s0_axi4_wstrb(s0_wstrb), .s1_axi4_wstrb(s1_wstrb),
    .s0_axi4_wlast(s0_wlast), .s1_axi4_wlast(s1_wlast),
    .s0_axi4_bvalid(s0_bvalid), .s1_axi4_bvalid(s1_bvalid), .s0_axi4_bready(s0_bready), .s1_axi4_bready(s1_bready),
    .s0_axi4_bid(s0_bid), .s1_axi4_bid(s1_bid), .s0_axi4_bresp(s0_bresp), .s1_axi4_bresp(s1_bresp),
    .s0_axi4_arvalid(s0_arvalid), .s1_axi4_arvalid(s1_arvalid), .s0_axi4_arready(s0_arready), .s1_axi4_arready(s1_arready),
    .s0_axi4_arid(s0_arid), .s1_axi4_arid(s1_arid), .s0_axi4_araddr(s0_araddr), .s1_axi4_araddr(s1_araddr),
    .s0_axi4_arlen(s0_arlen), .s1_axi4_arlen(s1_arlen), .s0_axi4_arsize(s0_arsize), .s1_axi4_arsize(s1_arsize),
    .s0_axi4_arburst(s0_arburst), .s1_axi4_arburst(s1_arburst),
    .s0_axi4_rvalid(s0_rvalid), .s1_axi4_rvalid(s1_rvalid), .s0_axi4_rready(s0_rready), .s1_axi4_rready(s1_rready),
    .s0_axi4_rid(s0_rid), .s1_axi4_rid(s1_rid), .s0_axi4_rdata(s0_rdata), .s1_axi4_rdata(s1_rdata),
    .s0_axi4_rresp(s0_rresp), .s1_axi4_rresp(s1_rresp), .s0_axi4_rlast(s0_rlast), .s1_axi4_rlast(s1_rlast),
    .m_axi4_awvalid(m_awvalid), .m_axi4_awready(m_awready), .m_axi4_awid(m_awid), .m_axi4_awaddr(m_awaddr),
    .m_axi4_awlen(m_awlen), .m_axi4_awsize(m_awsize), .m_axi4_awburst(m_awburst),
    .m_axi4_wvalid(m_wvalid), .m_axi4_wready(m_wready), .m_axi4_wdata(m_wdata), .m_axi4_wstrb(m_wstrb), .m_axi4_wlast(m_wlast),
    .m_axi4_bvalid(m_bvalid), .m_axi4_bready(m_bready), .m_axi4_bid(m_bid), .m_axi4_bresp(m_bresp),
    .m_axi4_arvalid(m_arvalid), .m_axi4_arready(m_arready), .m_axi4_arid(m_arid), .m_axi4_araddr(m_araddr),
    .m_axi4_arlen(m_arlen), .m_axi4_arsize(m_arsize), .m_axi4_arburst(m_arburst),
    .m_axi4_rvalid(m_rvalid), .m_axi4_rready(m_rready), .m_axi4_rid(m_rid), .m_axi4_rdata(m_rdata),
    .m_axi4_rresp(m_rresp), .m_axi4_rlast(m_rlast),
    .wr_owner(wr_owner), .rd_owner(rd_owner), .wr_busy(wr_busy), .rd_busy(rd_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    s0_awvalid = 0; s0_awid = '0; s0_awaddr = '0; s0_awlen = '0; s0_awsize = 3'd3; s0_awburst = BURST_INCR;
    s1_awvalid = 0; s1_awid = '0; s1_awaddr = '0; s1_awlen = '0; s1_awsize = 3'd3; s1_awburst = BURST_INCR;
    s0_wvalid = 0; s0_wdata = '0; s0_wstrb = '1; s0_wlast = 0; s0_bready = 0;
    s1_wvalid = 0; s1_wdata = '0; s1_wstrb = '1; s1_wlast = 0; s1_bready = 0;
    s0_arvalid = 0; s0_arid = '0; s0_araddr = '0; s0_arlen = '0; s0_arsize = 3'd3; s0_arburst = BURST_INCR;
    s1_arvalid = 0; s1_arid = '0; s1_araddr = '0; s1_arlen = '0; s1_arsize = 3'd3; s1_arburst = BURST_INCR;
    s0_rready = 0; s1_rready = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bid = '0; m_bresp = RESP_OKAY;
    m_arready = 0; m_rvalid = 0; m_rid = '0; m_rdata = '0; m_rresp = RESP_OKAY; m_rlast = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask

  int  wb, rb, g, n0, n1, stall;
  bit  bdone, awd, ard, overlap;
  logic own_w, own_r;

  initial begin
    // Single 4-beat write from s0, preceded by reset-state and spurious-response checks
    do_reset();
    #2;
    chk("rst_wr_busy", wr_busy, 0); chk("rst_rd_busy", rd_busy, 0);
    chk("rst_wr_owner", wr_owner, 0); chk("rst_rd_owner", rd_owner, 0);
    chk("rst_m_awvalid", m_awvalid, 0); chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_s0_awready", s0_awready, 0); chk("rst_s1_arready", s1_arready, 0);
    nxt();
    m_bvalid = 1; m_rvalid = 1; m_rlast = 1; s0_bready = 1; s0_rready = 1;
    #2;
    chk("spur_m_bready", m_bready, 0); chk("spur_m_rready", m_rready, 0);
    chk("spur_s0_bvalid", s0_bvalid, 0); chk("spur_s0_rvalid", s0_rvalid, 0);
    nxt();
    idle_inputs();
    s0_awvalid = 1; s0_awid = 4'd5; s0_awaddr = 31'h1000; s0_awlen = 8'd3; m_awready = 1;
    #2;
    chk("t1_awvalid_same_cycle", m_awvalid, 0);
    nxt(); #2;
    chk("t1_awvalid_next_cycle", m_awvalid, 1); chk("t1_awaddr", m_awaddr, 64'h1000);
    chk("t1_awlen", m_awlen, 3); chk("t1_awid", m_awid, 5);
    chk("t1_s0_awready", s0_awready, 1); chk("t1_s1_awready", s1_awready, 0);
    chk("t1_wr_owner", wr_owner, 0); chk("t1_wr_busy", wr_busy, 1);
    nxt();
    s0_awvalid = 0; m_awready = 0; m_wready = 1; wb = 0;
    for (int c = 0; c < 20 && wb < 4; c++) begin
      s0_wvalid = 1; s0_wdata = 64'h11 * 64'(wb + 1); s0_wlast = (wb == 3);
      #2;
      if (m_wvalid && m_wready) begin
        chk("t1_wdata", m_wdata, 64'h11 * 64'(wb + 1));
        wb++;
      end
      nxt();
    end
    chk("t1_wbeats", 64'(wb), 4);
    s0_wvalid = 0; s0_wlast = 0; m_wready = 0;
    m_bvalid = 1; m_bid = 4'd5; m_bresp = RESP_OKAY; s0_bready = 1;
    #2;
    chk("t1_s0_bvalid", s0_bvalid, 1); chk("t1_s0_bid", s0_bid, 5); chk("t1_s0_bresp", s0_bresp, RESP_OKAY);
    chk("t1_s1_bvalid", s1_bvalid, 0); chk("t1_m_bready", m_bready, 1);
    nxt(); idle_inputs(); #2;
    chk("t1_idle_after_b", wr_busy, 0);

    // Simultaneous reads: s0 first, s1 held off until s0's last beat
    do_reset();
    s0_arvalid = 1; s0_arid = 4'd3; s0_araddr = 31'h2000; s0_arlen = 8'd1;
    s1_arvalid = 1; s1_arid = 4'd7; s1_araddr = 31'h3000; s1_arlen = 8'd1; m_arready = 1;
    #2;
    chk("t2_arvalid_same_cycle", m_arvalid, 0);
    nxt(); #2;
    chk("t2_araddr_s0", m_araddr, 64'h2000); chk("t2_arid_s0", m_arid, 3); chk("t2_rd_owner0", rd_owner, 0);
    chk("t2_s0_arready", s0_arready, 1); chk("t2_s1_arready", s1_arready, 0);
    nxt();
    s0_arvalid = 0; s0_rready = 1; s1_rready = 1;
    m_rvalid = 1; m_rid = 4'd3; m_rdata = 64'hAAAA_0001; m_rlast = 0;
    #2;
    chk("t2_s0_rvalid_b0", s0_rvalid, 1); chk("t2_s0_rdata_b0", s0_rdata, 64'hAAAA_0001);
    chk("t2_s1_rvalid_b0", s1_rvalid, 0);
    nxt();
    m_rdata = 64'hAAAA_0002; m_rlast = 1;
    #2;
    chk("t2_s0_rlast", s0_rlast, 1); chk("t2_s0_rdata_b1", s0_rdata, 64'hAAAA_0002);
    chk("t2_s1_rvalid_b1", s1_rvalid, 0);
    nxt();
    m_rvalid = 0; m_rlast = 0;
    #2;
    chk("t2_bubble_busy", rd_busy, 0); chk("t2_bubble_arvalid", m_arvalid, 0);
    nxt(); #2;
    chk("t2_rd_owner1", rd_owner, 1); chk("t2_araddr_s1", m_araddr, 64'h3000);
    chk("t2_arid_s1", m_arid, 7); chk("t2_s1_arready", s1_arready, 1);
    nxt();
    s1_arvalid = 0; m_rvalid = 1; m_rid = 4'd7; m_rdata = 64'hBBBB_0001; m_rlast = 1;
    #2;
    chk("t2_s1_rvalid", s1_rvalid, 1); chk("t2_s1_rdata", s1_rdata, 64'hBBBB_0001);
    chk("t2_s1_rid", s1_rid, 7); chk("t2_s0_rvalid_late", s0_rvalid, 0);
    nxt(); idle_inputs(); #2;
    chk("t2_done", rd_busy, 0);

    // Fairness: both masters stream single-beat writes
    do_reset();
    s0_awvalid = 1; s0_awid = 4'd1; s1_awvalid = 1; s1_awid = 4'd2;
    s0_wvalid = 1; s0_wlast = 1; s1_wvalid = 1; s1_wlast = 1; s0_bready = 1; s1_bready = 1;
    m_awready = 1; m_wready = 1; m_bvalid = 1;
    g = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 80 && g < 8; c++) begin
      #2;
      if (m_awvalid && m_awready) begin
        chk("t3_grant_owner", wr_owner, 64'(g % 2));
        chk("t3_grant_awid", m_awid, (g % 2 == 1) ? 64'd2 : 64'd1);
        if (m_awid == 4'd1) n0++;
        else n1++;
        g++;
      end
      nxt();
    end
    chk("t3_grants", 64'(g), 8); chk("t3_s0_count", 64'(n0), 4); chk("t3_s1_count", 64'(n1), 4);

    // Concurrent paths: s0 writes 8 beats while s1 reads 8 beats
    do_reset();
    s0_awid = 4'd4; s0_awaddr = 31'h4000; s0_awlen = 8'd7;
    s1_arid = 4'd9; s1_araddr = 31'h5000; s1_arlen = 8'd7;
    m_awready = 1; m_arready = 1; m_wready = 1; s0_bready = 1; s1_rready = 1;
    wb = 0; rb = 0; bdone = 0; awd = 0; ard = 0; overlap = 0; own_w = 1; own_r = 0;
    for (int c = 0; c < 60 && !(bdone && rb == 8); c++) begin
      s0_awvalid = !awd; s1_arvalid = !ard;
      s0_wvalid = (wb < 8); s0_wdata = 64'h4000 + 64'(wb); s0_wlast = (wb == 7);
      m_rvalid = (rb < 8); m_rid = 4'd9; m_rdata = 64'h5000 + 64'(rb); m_rlast = (rb == 7);
      m_bvalid = (wb == 8) && !bdone; m_bid = 4'd4;
      #2;
      if (s0_awready) awd = 1;
      if (s1_arready) ard = 1;
      if (m_wvalid && m_wready && m_rvalid && m_rready && !overlap) begin
        overlap = 1; own_w = wr_owner; own_r = rd_owner;
      end
      if (m_wvalid && m_wready) begin
        chk("t4_wdata", m_wdata, 64'h4000 + 64'(wb));
        wb++;
      end
      if (s1_rvalid && s1_rready) begin
        chk("t4_rdata", s1_rdata, 64'h5000 + 64'(rb));
        rb++;
      end
      if (s0_bvalid && s0_bready) begin
        chk("t4_bid", s0_bid, 4);
        bdone = 1;
      end
      nxt();
    end
    chk("t4_wbeats", 64'(wb), 8); chk("t4_rbeats", 64'(rb), 8); chk("t4_bdone", 64'(bdone), 1);
    chk("t4_overlap", 64'(overlap), 1); chk("t4_wr_owner", own_w, 0); chk("t4_rd_owner", own_r, 1);
    idle_inputs();

    // Early W from s1 plus three cycles of slave backpressure
    do_reset();
    s1_wvalid = 1; s1_wdata = 64'hA1; s1_wlast = 0;
    #2;
    chk("t5_early_wready", s1_wready, 0); chk("t5_early_m_wvalid", m_wvalid, 0);
    nxt();
    s1_awid = 4'd6; s1_awaddr = 31'h6000; s1_awlen = 8'd1; m_awready = 1; s1_bready = 1;
    wb = 0; stall = 0; bdone = 0; awd = 0;
    for (int c = 0; c < 40 && !bdone; c++) begin
      s1_awvalid = !awd;
      s1_wvalid = (wb < 2); s1_wdata = 64'hA1 + 64'(wb); s1_wlast = (wb == 1);
      m_bvalid = (wb == 2) && !bdone; m_bid = 4'd6;
      #1;
      m_wready = m_wvalid && (stall >= 3);
      #1;
      if (s1_awready) awd = 1;
      if (!m_wvalid) chk("t5_no_data_wready", s1_wready, 0);
      if (m_wvalid && !m_wready) begin
        chk("t5_stall_wready", s1_wready, 0);
        stall++;
      end
      if (m_wvalid && m_wready) begin
        chk("t5_wdata", m_wdata, 64'hA1 + 64'(wb));
        wb++;
      end
      if (s1_bvalid && s1_bready) bdone = 1;
      nxt();
    end
    chk("t5_wbeats", 64'(wb), 2); chk("t5_stalls", 64'(stall), 3); chk("t5_bdone", 64'(bdone), 1);
    idle_inputs();

    // Reset during beat 2 of an 8-beat read, then a fresh single-beat read
    do_reset();
    s0_arvalid = 1; s0_arid = 4'd2; s0_araddr = 31'h6000; s0_arlen = 8'd7; m_arready = 1; s0_rready = 1;
    nxt(); nxt();
    s0_arvalid = 0; m_rvalid = 1; m_rid = 4'd2; m_rdata = 64'h1;
    #2;
    chk("t6_beat1", s0_rvalid, 1);
    nxt();
    m_rdata = 64'h2; reset = 1;
    #2;
    nxt(); #2;
    chk("t6_rst_rd_busy", rd_busy, 0); chk("t6_rst_wr_busy", wr_busy, 0);
    chk("t6_rst_m_rready", m_rready, 0); chk("t6_rst_s0_rvalid", s0_rvalid, 0);
    chk("t6_rst_m_arvalid", m_arvalid, 0); chk("t6_rst_rd_owner", rd_owner, 0);
    reset = 0; m_rvalid = 0; s0_rready = 0;
    s1_arvalid = 1; s1_arid = 4'd8; s1_araddr = 31'h7000; s1_arlen = 8'd0; s1_rready = 1;
    nxt(); #2;
    chk("t6_new_araddr", m_araddr, 64'h7000); chk("t6_new_owner", rd_owner, 1);
    nxt();
    s1_arvalid = 0; m_rvalid = 1; m_rlast = 1; m_rid = 4'd8; m_rdata = 64'hCAFE;
    #2;
    chk("t6_new_rvalid", s1_rvalid, 1); chk("t6_new_rdata", s1_rdata, 64'hCAFE);
    nxt(); idle_inputs(); #2;
    chk("t6_new_done", rd_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
